// File: rtl/cprv_wb_stage_if.sv
// Write-back stage bundle: mem-stage offer/handshake, register-file write port and retire count.
interface cprv_wb_stage_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  valid_wb_i;
  logic                  ready_wb_o;
  logic [4:0]            rd_addr_wb_i;
  logic                  rd_en_wb_i;
  logic [6:0]            opcode_wb_i;
  logic [2:0]            funct3_wb_i;
  logic [DATA_WIDTH-1:0] alu_out_wb_i;
  logic [DATA_WIDTH-1:0] rdata_wb_i;
  logic                  rf_ready_i;
  logic                  rd_w_en_o;
  logic [4:0]            rd_addr_o;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic [63:0]           instret_o;

  modport master (
    output valid_wb_i, rd_addr_wb_i, rd_en_wb_i, opcode_wb_i, funct3_wb_i,
           alu_out_wb_i, rdata_wb_i, rf_ready_i,
    input  ready_wb_o, rd_w_en_o, rd_addr_o, rd_data_o, instret_o
  );

  modport slave (
    input  valid_wb_i, rd_addr_wb_i, rd_en_wb_i, opcode_wb_i, funct3_wb_i,
           alu_out_wb_i, rdata_wb_i, rf_ready_i,
    output ready_wb_o, rd_w_en_o, rd_addr_o, rd_data_o, instret_o
  );
endinterface

// File: rtl/cprv_wb_stage.sv
// Write-back stage: one-entry EMPTY/FULL buffer that aligns load data at accept,
// writes the register file when it is ready, and counts retired instructions.
module cprv_wb_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int WORD_WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  cprv_wb_stage_if.slave wb
);
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  if (WORD_WIDTH < 8 || DATA_WIDTH < 32) begin : g_width_check
    $error("cprv_wb_stage: unsupported DATA_WIDTH/WORD_WIDTH");
  end

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state;
  logic [4:0]            rd_addr_p1;
  logic                  rd_en_p1;
  logic [DATA_WIDTH-1:0] result_p1;
  logic [63:0]           instret_cnt;

  logic                  occupied;
  logic                  ready;
  logic                  accept;
  logic                  commit;
  logic [DATA_WIDTH-1:0] result_p0;

  // Bytes shifted in from above the doubleword are zero, so misaligned loads
  // simply see zero-filled upper bytes.
  function automatic logic [DATA_WIDTH-1:0] load_align(
    input logic [DATA_WIDTH-1:0] rdata,
    input logic [2:0]            offset,
    input logic [2:0]            funct3
  );
    logic [DATA_WIDTH-1:0] s;
    s = rdata >> {offset, 3'b000};
    case (funct3)
      3'b000:  load_align = {{(DATA_WIDTH-8){s[7]}}, s[7:0]};
      3'b001:  load_align = {{(DATA_WIDTH-16){s[15]}}, s[15:0]};
      3'b010:  load_align = {{(DATA_WIDTH-32){s[31]}}, s[31:0]};
      3'b011:  load_align = rdata;
      3'b100:  load_align = {{(DATA_WIDTH-8){1'b0}}, s[7:0]};
      3'b101:  load_align = {{(DATA_WIDTH-16){1'b0}}, s[15:0]};
      3'b110:  load_align = {{(DATA_WIDTH-32){1'b0}}, s[31:0]};
      default: load_align = '0;
    endcase
  endfunction

  assign occupied = (state == FULL);
  assign ready    = !occupied || wb.rf_ready_i;
  assign accept   = wb.valid_wb_i && ready;
  assign commit   = occupied && wb.rf_ready_i;

  // p0: result selection on the incoming instruction
  assign result_p0 = (wb.opcode_wb_i == OP_LOAD)
                   ? load_align(wb.rdata_wb_i, wb.alu_out_wb_i[2:0], wb.funct3_wb_i)
                   : wb.alu_out_wb_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      rd_addr_p1  <= '0;
      rd_en_p1    <= 1'b0;
      result_p1   <= '0;
      instret_cnt <= '0;
    end else begin
      if (commit) begin
        instret_cnt <= instret_cnt + 64'd1;
      end
      if (accept) begin
        state      <= FULL;
        rd_addr_p1 <= wb.rd_addr_wb_i;
        rd_en_p1   <= wb.rd_en_wb_i;
        result_p1  <= result_p0;
      end else if (commit) begin
        state <= EMPTY;
      end
    end
  end

  // p1: register-file write port driven from the stage register
  assign wb.ready_wb_o = ready;
  assign wb.rd_w_en_o  = commit && rd_en_p1 && (rd_addr_p1 != 5'd0);
  assign wb.rd_addr_o  = occupied ? rd_addr_p1 : 5'd0;
  assign wb.rd_data_o  = occupied ? result_p1 : '0;
  assign wb.instret_o  = instret_cnt;
endmodule

// File: tb/tb_cprv_wb_stage.sv
// Bench for cprv_wb_stage: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_cprv_wb_stage;
  localparam int DW = 64;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cprv_wb_stage_if #(.DATA_WIDTH(DW)) wb();

  cprv_wb_stage #(.DATA_WIDTH(DW), .WORD_WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .wb (wb)
  );

  int checks   = 0;
  int failures = 0;

  // Model of the stage: what is held, and how many instructions have retired.
  bit          m_full;
  logic [4:0]  m_addr;
  bit          m_en;
  logic [63:0] m_data;
  logic [63:0] m_instret;

  function automatic logic [63:0] ref_result(input logic [6:0] op, input logic [2:0] f3,
                                             input logic [63:0] alu, input logic [63:0] rdata);
    logic [63:0] v;
    int nbytes;
    int off;
    if (op != OP_LOAD) return alu;
    if (f3 == 3'b011) return rdata;
    if (f3 == 3'b111) return 64'd0;
    nbytes = 1 << f3[1:0];
    off    = int'(alu[2:0]);
    v      = 64'd0;
    for (int k = 0; k < nbytes; k++) begin
      if (off + k < 8) v[8*k +: 8] = rdata[8*(off+k) +: 8];
    end
    if (!f3[2] && v[8*nbytes-1]) begin
      for (int b = 8*nbytes; b < 64; b++) v[b] = 1'b1;
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [4:0] rd, input bit en, input logic [6:0] op,
                       input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] rdata,
                       input bit rfr);
    wb.valid_wb_i   = v;
    wb.rd_addr_wb_i = rd;
    wb.rd_en_wb_i   = en;
    wb.opcode_wb_i  = op;
    wb.funct3_wb_i  = f3;
    wb.alu_out_wb_i = alu;
    wb.rdata_wb_i   = rdata;
    wb.rf_ready_i   = rfr;
  endtask

  task automatic idle(input bit rfr);
    drive(1'b0, 5'd0, 1'b0, 7'd0, 3'd0, 64'd0, 64'd0, rfr);
  endtask

  task automatic compare_outputs();
    bit rf;
    rf = wb.rf_ready_i;
    check("ready",   {63'd0, wb.ready_wb_o}, {63'd0, (!m_full || rf)});
    check("rd_w_en", {63'd0, wb.rd_w_en_o},  {63'd0, (m_full && rf && m_en && m_addr != 5'd0)});
    check("rd_addr", {59'd0, wb.rd_addr_o},  {59'd0, (m_full ? m_addr : 5'd0)});
    check("rd_data", wb.rd_data_o,           m_full ? m_data : 64'd0);
    check("instret", wb.instret_o,           m_instret);
  endtask

  task automatic model_edge();
    bit rdy, acc, com;
    if (rst) begin
      m_full = 0; m_addr = '0; m_en = 0; m_data = '0; m_instret = '0;
      return;
    end
    rdy = !m_full || wb.rf_ready_i;
    acc = wb.valid_wb_i && rdy;
    com = m_full && wb.rf_ready_i;
    if (com) m_instret = m_instret + 64'd1;
    if (acc) begin
      m_full = 1;
      m_addr = wb.rd_addr_wb_i;
      m_en   = wb.rd_en_wb_i;
      m_data = ref_result(wb.opcode_wb_i, wb.funct3_wb_i, wb.alu_out_wb_i, wb.rdata_wb_i);
    end else if (com) begin
      m_full = 0;
    end
  endtask

  // One clock: compare current outputs, then advance the model at the edge.
  task automatic cyc();
    #1 compare_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  logic [63:0] snap;

  initial begin
    rst = 1'b1;
    idle(1'b1);
    m_full = 0; m_addr = '0; m_en = 0; m_data = '0; m_instret = '0;
    @(negedge clk);
    cyc();
    #1;
    check("reset_ready",   {63'd0, wb.ready_wb_o}, 64'd1);
    check("reset_instret", wb.instret_o, 64'd0);
    check("reset_rd_data", wb.rd_data_o, 64'd0);
    rst = 1'b0;
    cyc();

    // ALU op
    drive(1, 5'd5, 1, OP_ALU, 3'd0, 64'h1234, 64'h5555, 1);
    cyc();
    idle(1'b1);
    #1;
    check("alu_w_en",  {63'd0, wb.rd_w_en_o}, 64'd1);
    check("alu_addr",  {59'd0, wb.rd_addr_o}, 64'd5);
    check("alu_data",  wb.rd_data_o, 64'h1234);
    cyc();
    #1 check("alu_instret", wb.instret_o, 64'd1);

    // LB / LBU at byte offset 7, back to back
    drive(1, 5'd7, 1, OP_LOAD, 3'b000, 64'h1007, 64'h80FF_0000_0000_0000, 1);
    cyc();
    drive(1, 5'd8, 1, OP_LOAD, 3'b100, 64'h1007, 64'h80FF_0000_0000_0000, 1);
    #1 check("lb_data", wb.rd_data_o, 64'hFFFF_FFFF_FFFF_FF80);
    cyc();
    idle(1'b1);
    #1 check("lbu_data", wb.rd_data_o, 64'h80);
    cyc();

    // x0 write suppressed but retired
    drive(1, 5'd0, 1, OP_ALU, 3'd0, 64'hDEAD, 64'd0, 1);
    cyc();
    idle(1'b1);
    snap = m_instret;
    #1 check("x0_w_en", {63'd0, wb.rd_w_en_o}, 64'd0);
    cyc();
    #1 check("x0_instret", wb.instret_o, snap + 64'd1);

    // Stall three cycles, then commit with back-to-back accept
    drive(1, 5'd10, 1, OP_ALU, 3'd0, 64'hAAAA, 64'd0, 1);
    cyc();
    snap = m_instret;
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd11, 1, OP_ALU, 3'd0, 64'hBBBB, 64'd0, 0);
      #1;
      check("stall_ready",   {63'd0, wb.ready_wb_o}, 64'd0);
      check("stall_data",    wb.rd_data_o, 64'hAAAA);
      check("stall_instret", wb.instret_o, snap);
      cyc();
    end
    drive(1, 5'd11, 1, OP_ALU, 3'd0, 64'hBBBB, 64'd0, 1);
    #1 check("stall_commit_w_en", {63'd0, wb.rd_w_en_o}, 64'd1);
    cyc();
    idle(1'b1);
    #1;
    check("b2b_addr", {59'd0, wb.rd_addr_o}, 64'd11);
    check("b2b_data", wb.rd_data_o, 64'hBBBB);
    cyc();

    // Reset while FULL and stalled
    drive(1, 5'd12, 1, OP_ALU, 3'd0, 64'hCCCC, 64'd0, 1);
    cyc();
    drive(1, 5'd13, 1, OP_ALU, 3'd0, 64'hDDDD, 64'd0, 0);
    cyc();
    rst = 1'b1;
    drive(1, 5'd14, 1, OP_ALU, 3'd0, 64'hEEEE, 64'd0, 0);
    cyc();
    rst = 1'b0;
    idle(1'b0);
    #1;
    check("rst_ready",   {63'd0, wb.ready_wb_o}, 64'd1);
    check("rst_instret", wb.instret_o, 64'd0);
    check("rst_data",    wb.rd_data_o, 64'd0);
    cyc();

    // Counter wrap from a forced value
    idle(1'b1);
    force dut.instret_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
    #1 release dut.instret_cnt;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFE;
    drive(1, 5'd3, 1, OP_ALU, 3'd0, 64'd1, 64'd0, 1);
    cyc();
    drive(1, 5'd4, 1, OP_ALU, 3'd0, 64'd2, 64'd0, 1);
    cyc();
    idle(1'b1);
    cyc();
    #1 check("wrap_instret", wb.instret_o, 64'd0);
    cyc();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 1) ? OP_LOAD : 7'($urandom),
            3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 99) < 70);
      cyc();
    end
    rst = 1'b0;
    idle(1'b1);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
